neural_network: RTL and testbench



---
 rtl/nn_pkg.sv | 43 ++++
 rtl/nn_neuron.sv | 43 ++++
 rtl/neural_network.sv | 86 ++++++++
 tb/tb_neural_network.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants, types and width helpers for the 4x4 perceptron.
// NN_SIGNED_EN selects two's-complement operands; default build is unsigned.
package nn_pkg;

    localparam int N_NEURONS = 4;
    localparam int N_INPUTS  = 4;
    localparam int DW        = 8;
    localparam int ACC_W     = 19;
    localparam int PW        = 2 * DW;

    // Parameter stream per neuron: threshold, bias, then one weight per input
    localparam int P_PER_NEURON = N_INPUTS + 2;
    localparam int P_BYTES      = N_NEURONS * P_PER_NEURON;

    typedef logic [DW-1:0]    byte_t;
    typedef logic [PW-1:0]    prod_t;
    typedef logic [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        LOAD_X  = 2'd0,
        LOAD_P  = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Widen an operand to accumulator width, sign- or zero-extending per build
    function automatic acc_t ext_byte(input byte_t v);
`ifdef NN_SIGNED_EN
        return {{(ACC_W-DW){v[DW-1]}}, v};
`else
        return {{(ACC_W-DW){1'b0}}, v};
`endif
    endfunction

    function automatic acc_t ext_prod(input prod_t v);
`ifdef NN_SIGNED_EN
        return {{(ACC_W-PW){v[PW-1]}}, v};
`else
        return {{(ACC_W-PW){1'b0}}, v};
`endif
    endfunction

endpackage

// File: rtl/nn_neuron.sv
// Combinational neuron: fire = (b + sum w_i*x_i) > th, strict compare.
// Signedness follows NN_SIGNED_EN.
module nn_neuron
    import nn_pkg::*;
(
    input  byte_t x [N_INPUTS],
    input  byte_t w [N_INPUTS],
    input  byte_t b,
    input  byte_t th,
    output logic  fire
);

    prod_t prod [N_INPUTS];
    acc_t  acc;
    acc_t  th_ext;

    // Full-width products of extended operands; the low PW bits are exact
    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_prod
`ifdef NN_SIGNED_EN
            assign prod[gi] = {{DW{w[gi][DW-1]}}, w[gi]} * {{DW{x[gi][DW-1]}}, x[gi]};
`else
            assign prod[gi] = {{DW{1'b0}}, w[gi]} * {{DW{1'b0}}, x[gi]};
`endif
        end
    endgenerate

    always_comb begin
        acc = ext_byte(b);
        for (int i = 0; i < N_INPUTS; i++) begin
            acc = acc + ext_prod(prod[i]);
        end
    end

    assign th_ext = ext_byte(th);

`ifdef NN_SIGNED_EN
    assign fire = $signed(acc) > $signed(th_ext);
`else
    assign fire = acc > th_ext;
`endif

endmodule

// File: rtl/neural_network.sv
// 4-neuron, 4-input perceptron loaded byte-serially; FSM, shift registers, output register.
// Build option NN_SIGNED_EN switches all operands to two's complement.
module neural_network
    import nn_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        changes,
    input  logic [7:0]  data_in,
    output logic [7:0]  network_outputs
);

    state_t                   state_reg;
    logic                     changes_q_reg;
    logic [N_INPUTS*DW-1:0]   x_sr_reg;
    logic [P_BYTES*DW-1:0]    p_sr_reg;
    logic                     chg_rise;
    logic [N_NEURONS-1:0]     fire;

    byte_t x_vec  [N_INPUTS];
    byte_t w_vec  [N_NEURONS][N_INPUTS];
    byte_t b_vec  [N_NEURONS];
    byte_t th_vec [N_NEURONS];

    assign chg_rise = changes & ~changes_q_reg;

    // Newest byte sits in the low lane, so x0 and w_00 land at byte 0
    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_x
            assign x_vec[gi] = x_sr_reg[gi*DW +: DW];
        end
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
            localparam int BASE = gi * P_PER_NEURON;
            for (genvar gk = 0; gk < N_INPUTS; gk++) begin : g_w
                assign w_vec[gi][gk] = p_sr_reg[(BASE+gk)*DW +: DW];
            end
            assign b_vec[gi]  = p_sr_reg[(BASE+N_INPUTS)*DW +: DW];
            assign th_vec[gi] = p_sr_reg[(BASE+N_INPUTS+1)*DW +: DW];

            nn_neuron u_neuron (
                .x    (x_vec),
                .w    (w_vec[gi]),
                .b    (b_vec[gi]),
                .th   (th_vec[gi]),
                .fire (fire[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= LOAD_X;
            changes_q_reg   <= 1'b0;
            x_sr_reg        <= '0;
            p_sr_reg        <= '0;
            network_outputs <= '0;
        end else begin
            changes_q_reg <= changes;
            case (state_reg)
                LOAD_X: begin
                    if (chg_rise)
                        state_reg <= LOAD_P;
                    else if (!changes)
                        x_sr_reg <= {x_sr_reg[(N_INPUTS-1)*DW-1:0], data_in};
                end
                LOAD_P: begin
                    if (chg_rise)
                        state_reg <= COMPUTE;
                    else if (!changes)
                        p_sr_reg <= {p_sr_reg[(P_BYTES-1)*DW-1:0], data_in};
                end
                COMPUTE: begin
                    network_outputs <= {{(8-N_NEURONS){1'b0}}, fire};
                    state_reg       <= DONE;
                end
                DONE: begin
                    // Shift registers keep their contents across a reload
                    if (chg_rise)
                        state_reg <= LOAD_X;
                end
                default: state_reg <= LOAD_X;
            endcase
        end
    end

endmodule

// File: tb/tb_neural_network.sv
// Directed bench for neural_network: expected fire patterns come from a behavioural
// model, are queued when a load is issued and popped when the output is sampled.
module tb_neural_network;

    logic       clk;
    logic       reset;
    logic       changes;
    logic [7:0] data_in;
    wire  [7:0] network_outputs;

    neural_network dut (
        .clk             (clk),
        .reset           (reset),
        .changes         (changes),
        .data_in         (data_in),
        .network_outputs (network_outputs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_q [$];
    logic [7:0] last_out;
    bit         in_done;

    int x_v  [4];
    int th_v [4];
    int b_v  [4];
    int w_v  [4][4];

    function automatic int as_val(input int v);
`ifdef NN_SIGNED_EN
        return (v >= 128) ? v - 256 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] model();
        logic [7:0] r;
        longint acc;
        r = 8'h00;
        for (int j = 0; j < 4; j++) begin
            acc = as_val(b_v[j]);
            for (int i = 0; i < 4; i++)
                acc += as_val(w_v[j][i]) * as_val(x_v[i]);
            r[j] = (acc > as_val(th_v[j]));
        end
        return r;
    endfunction

    task automatic set_nominal();
        x_v[3] = 10; x_v[2] = 9; x_v[1] = 8; x_v[0] = 7;
        for (int j = 0; j < 4; j++) begin
            th_v[j] = 0;
            b_v[j]  = j + 1;
            for (int i = 0; i < 4; i++) w_v[j][i] = j + 1;
        end
    endtask

    task automatic send_byte(input int v);
        data_in = v[7:0];
        changes = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse(input int hold);
        changes = 1'b1;
        repeat (hold) @(negedge clk);
        changes = 1'b0;
    endtask

    task automatic check(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        compared++;
        assert (network_outputs === e)
        else begin
            mismatched++;
            $error("FAIL %s: observed %02h expected %02h", tag, network_outputs, e);
        end
    endtask

    task automatic send_x(input bit overlong);
        if (overlong) begin
            send_byte(1);
            send_byte(2);
        end
        for (int i = 3; i >= 0; i--) send_byte(x_v[i]);
    endtask

    task automatic send_p(input int count);
        int n;
        n = 0;
        for (int j = 3; j >= 0; j--) begin
            if (n < count) begin send_byte(th_v[j]); n++; end
            if (n < count) begin send_byte(b_v[j]);  n++; end
            for (int i = 3; i >= 0; i--)
                if (n < count) begin send_byte(w_v[j][i]); n++; end
        end
    endtask

    task automatic run_load(input string tag, input int hold, input bit overlong);
        logic [7:0] e;
        if (in_done) pulse(1);
        send_x(overlong);
        pulse(hold);
        send_p(24);
        e = model();
        pulse(hold);
        if (hold == 1) begin
            // One edge after the advance the output must not yet have moved
            exp_q.push_back(last_out);
            check({tag, "_early"});
        end
        repeat (2) @(negedge clk);
        exp_q.push_back(e);
        check({tag, "_out"});
        last_out = e;
        for (int k = 0; k < 3; k++) send_byte($urandom_range(255));
        exp_q.push_back(e);
        check({tag, "_hold"});
        $display("load %-10s exp=%02h got=%02h", tag, e, network_outputs);
        in_done = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        changes  = 1'b0;
        data_in  = 8'h00;
        last_out = 8'h00;
        in_done  = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h00);
        check("reset_state");
        reset = 1'b0;
        @(negedge clk);

        set_nominal();
        run_load("nominal", 1, 1'b0);

        th_v[3] = 140;
        run_load("th3_140", 1, 1'b0);
        th_v[3] = 139;
        run_load("th3_139", 1, 1'b0);

        set_nominal();
        run_load("overlong", 1, 1'b1);
        run_load("held", 5, 1'b0);

        // Asynchronous reset part-way through the parameter stream
        pulse(1);
        send_x(1'b0);
        pulse(1);
        send_p(7);
        reset = 1'b1;
        #1;
        exp_q.push_back(8'h00);
        check("rst_async");
        @(negedge clk);
        exp_q.push_back(8'h00);
        check("rst_held");
        reset    = 1'b0;
        last_out = 8'h00;
        in_done  = 1'b0;
        @(negedge clk);
        exp_q.push_back(8'h00);
        check("rst_after");
        run_load("post_rst", 1, 1'b0);

`ifdef NN_SIGNED_EN
        for (int i = 0; i < 4; i++) x_v[i] = 10;
        for (int j = 0; j < 4; j++) begin
            th_v[j] = 0;
            b_v[j]  = 0;
            for (int i = 0; i < 4; i++) w_v[j][i] = 8'hFF;
        end
        run_load("signed", 1, 1'b0);
`else
        for (int i = 0; i < 4; i++) x_v[i] = 255;
        for (int j = 0; j < 4; j++) begin
            th_v[j] = 255;
            b_v[j]  = 255;
            for (int i = 0; i < 4; i++) w_v[j][i] = 255;
        end
        run_load("saturate", 1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
